bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Shares the single 8-bit memory/data bus between NUM_REQ requesters: CPU fetch/execute sequencing, DMA, debug/UART loader and spare.
- Round-robin arbitration with a bounded ownership window.
- A per-requester lock keeps multi-cycle transfers atomic, such as a MOV fetch/load/store sequence.
- A turnaround gap (all grants low) separates owners so tri-state drivers never overlap.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); index 0 = CPU.
- MAX_HOLD, 8, max cycles an unlocked owner keeps the bus while others wait (≥2).
- TURNAROUND, 1, idle cycles with no grant between owners (1..3).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester bus request, level, held until done.
- lock  in  NUM_REQ  per-requester atomic hold; only meaningful for the current owner while its req=1.
- grant  out  NUM_REQ  one-hot bus grant, registered; all-zero when no owner.
- grant_valid  out  1  OR of grant, registered.
- grant_id  out  $clog2(NUM_REQ)  index of current/last owner, registered.
- preempt  out  1  one-cycle pulse: owner was forced off by the MAX_HOLD limit.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, grant=0, grant_valid=0, grant_id=0, preempt=0, hold_cnt=0.
  - last_id=NUM_REQ-1, so requester 0 wins first.
  - Reset mid-ownership drops grant immediately, with no turnaround.
- All outputs are registered. Only one grant bit is ever high. grant_valid equals the OR of grant every cycle.
- Round-robin pick: first set req bit scanning from last_id+1 upward, wrapping NUM_REQ-1 -> 0. last_id := winner on entry to OWN.
- States: IDLE, OWN, TURN.
- IDLE:
  - grant=0.
  - If any req=1 at edge k: winner granted after edge k (grant high in cycle k+1; 1-cycle latency). Go to OWN, hold_cnt=0.
- OWN (owner w):
  - grant[w]=1, grant_id=w. hold_cnt increments each cycle, saturating at MAX_HOLD-1.
  - req[w]=0 sampled -> TURN. grant drops on that edge, regardless of lock.
  - Otherwise, if hold_cnt==MAX_HOLD-1 and lock[w]=0 and another req bit is set -> TURN, with preempt=1 for one cycle.
  - lock[w]=1 suppresses preemption indefinitely. No timeout on locked transfers.
  - No other requester pending -> owner keeps the bus unbounded. The hold_cnt limit is checked the cycle a competitor appears.
- TURN:
  - grant=0 for exactly TURNAROUND cycles.
  - Arbitration is sampled on the last TURN cycle. Any req -> OWN with new winner; else IDLE.
  - A requester that drops req during TURN is not granted.
  - The previous owner may re-win only if no other req is set (round-robin guarantees this).
- Requests changing in the same cycle as a release: the sampled value at the deciding edge is the only input.
- Fairness bound: a continuously requesting, unlocked-competitor-only requester is granted within (NUM_REQ-1)*(MAX_HOLD+TURNAROUND)+1 cycles.
- grant_id holds the last owner value during TURN/IDLE.
- Internal counters: hold_cnt width $clog2(MAX_HOLD). Turnaround counter width $clog2(TURNAROUND+1).

Test Plan:
- Reset release, req=0001 held 3 cycles -> grant=0001 one cycle after first sampled req, grant_id=0. Drop req -> grant=0000 for 1 cycle, then IDLE.
- req=1111 continuous, no locks, defaults -> owners 0,1,2,3,0 in order. Each holds 8 cycles, preempt pulses 4 times, 1-cycle gap between each.
- Owner 1 with lock[1]=1 for 20 cycles while req[2]=1 -> grant stays 0010 all 20 cycles, no preempt. lock drop -> preempted at next limit check, grant 0100 after 1 gap cycle.
- req[0]=1 alone for 30 cycles, then req[3] rises at cycle 30 -> owner 0 released at that edge (hold_cnt saturated), preempt=1, grant=1000 after turnaround.
- reset=0 asserted mid-OWN (grant=0100) -> grant=0000 asynchronously. After release, req=0110 -> requester 1 wins (last_id reset to 3).
- TURNAROUND=3, req[2] pulses 1-cycle high inside the gap and drops -> no grant to 2; return to IDLE with grant=0000.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared 8-bit memory/data bus, with per-owner lock,
// bounded ownership window and an all-grants-low turnaround gap between owners.
module bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int MAX_HOLD   = 8,
    parameter int TURNAROUND = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         lock,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       preempt
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD);
    localparam int TURN_W = $clog2(TURNAROUND + 1);

    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD - 1);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURNAROUND - 1);
    localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_TURN
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [TURN_W-1:0]   turn_cnt_q, turn_cnt_d;
    logic [ID_W-1:0]     last_id_q, last_id_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                grant_valid_q, grant_valid_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic                preempt_q, preempt_d;

    logic                pick_found;
    logic [ID_W-1:0]     pick_id;
    logic                owner_req;
    logic                owner_lock;
    logic                competitor;
    logic                do_preempt;

    // grant_q is one-hot on the owner while in OWN, so it doubles as the owner mask.
    assign owner_req  = |(req & grant_q);
    assign owner_lock = |(lock & grant_q);
    assign competitor = |(req & ~grant_q);

    // Scan downward in offset so the nearest requester after last_id overwrites the rest.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        pick_found = 1'b0;
        pick_id    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            int idx;
            idx = (int'(last_id_q) + i) % NUM_REQ;
            if (req[idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: flops use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q       <= ST_IDLE;
            hold_cnt_q    <= '0;
            turn_cnt_q    <= '0;
            last_id_q     <= ID_LAST;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            preempt_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            turn_cnt_q    <= turn_cnt_d;
            last_id_q     <= last_id_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            preempt_q     <= preempt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        turn_cnt_d = turn_cnt_q;
        last_id_d  = last_id_q;
        do_preempt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d    = ST_OWN;
                    hold_cnt_d = '0;
                    last_id_d  = pick_id;
                end
            end
            ST_OWN: begin
                if (!owner_req) begin
                    state_d    = ST_TURN;
                    turn_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_MAX && !owner_lock && competitor) begin
                    state_d    = ST_TURN;
                    turn_cnt_d = '0;
                    do_preempt = 1'b1;
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_TURN: begin
                if (turn_cnt_q == TURN_LAST) begin
                    if (pick_found) begin
                        state_d    = ST_OWN;
                        hold_cnt_d = '0;
                        last_id_d  = pick_id;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    turn_cnt_d = turn_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: outputs are registered copies of what the next state implies.
    always_comb begin
        grant_d    = '0;
        grant_id_d = grant_id_q;
        preempt_d  = do_preempt;
        if (state_d == ST_OWN) begin
            grant_d    = NUM_REQ'(1) << last_id_d;
            grant_id_d = last_id_d;
        end
        grant_valid_d = |grant_d;
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign preempt     = preempt_q;

endmodule
